multicycle_cpu: RTL and testbench



---
 rtl/multicycle_cpu_pkg.sv | 34 +++
 rtl/multicycle_cpu_memory.sv | 27 ++
 rtl/multicycle_cpu.sv | 157 +++++++++++++++
 tb/tb_multicycle_cpu.sv | 106 ++++++++++
 4 files changed

// File: rtl/multicycle_cpu_pkg.sv
// Shared definitions for the multicycle MIPS-subset core: opcodes, functs,
// FSM and ALU encodings, and the decoder's "is this instruction supported" check.
package multicycle_cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_SLT, ALU_XOR} alu_op_t;

    // Unsupported encodings retire as NOPs straight out of DECODE.
    function automatic logic is_known(input logic [5:0] op, input logic [5:0] funct);
        case (op)
            OP_RTYPE: return (funct == FN_JR) || (funct == FN_ADD) ||
                             (funct == FN_SUB) || (funct == FN_SLT);
            OP_J, OP_JAL, OP_BEQ, OP_BNE,
            OP_ADDI, OP_XORI, OP_LW, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_cpu_memory.sv
// Unified instruction/data RAM: combinational read, synchronous write.
// Word index is addr[AW+1:2]; higher address bits wrap (MEM_WORDS is a power of two).
module multicycle_cpu_memory #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);

    localparam int unsigned AW = $clog2(MEM_WORDS);

    logic [31:0]   mem [0:MEM_WORDS-1];
    logic [AW-1:0] idx;
    logic          unused_addr;

    assign idx         = addr[AW+1:2];
    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
    assign rdata       = mem[idx];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle MIPS-subset core: 5-state FSM, inline ALU and register file.
// Define TRACE_EN to print a retirement trace line per instruction.
module multicycle_cpu
    import multicycle_cpu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input logic clk,
    input logic reset
);

    state_t      state;
    logic [31:0] pc, ir, a, b, aluout, mdr;
    logic [31:0] regs [0:31];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, wb_dest;
    logic [31:0] sext, zext, jump_target, alu_b, alu_y, wb_val;
    logic [31:0] mem_addr, mem_rdata;
    logic        mem_we;
    alu_op_t     alu_op;

    assign op          = ir[31:26];
    assign rs          = ir[25:21];
    assign rt          = ir[20:16];
    assign rd          = ir[15:11];
    assign funct       = ir[5:0];
    assign sext        = {{16{ir[15]}}, ir[15:0]};
    assign zext        = {16'h0000, ir[15:0]};
    assign jump_target = {pc[31:28], ir[25:0], 2'b00};

    assign mem_addr = (state == FETCH) ? pc : aluout;
    assign mem_we   = (state == MEM) && (op == OP_SW);
    assign wb_dest  = (op == OP_RTYPE) ? rd : rt;
    assign wb_val   = (op == OP_LW) ? mdr : aluout;

    multicycle_cpu_memory #(.MEM_WORDS(MEM_WORDS)) memory (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (b),
        .rdata (mem_rdata)
    );

    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = sext;
        if (op == OP_RTYPE) begin
            alu_b = b;
            if (funct == FN_SUB)      alu_op = ALU_SUB;
            else if (funct == FN_SLT) alu_op = ALU_SLT;
        end else if (op == OP_XORI) begin
            alu_b  = zext;
            alu_op = ALU_XOR;
        end
        case (alu_op)
            ALU_SUB: alu_y = a - alu_b;
            ALU_SLT: alu_y = 32'($signed(a) < $signed(alu_b));
            ALU_XOR: alu_y = a ^ alu_b;
            default: alu_y = a + alu_b;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            aluout <= '0;
            mdr    <= '0;
            for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            case (state)
                FETCH: begin
                    ir    <= mem_rdata;
                    pc    <= pc + 32'd4;
                    state <= DECODE;
                end
                DECODE: begin
                    a      <= regs[rs];
                    b      <= regs[rt];
                    aluout <= pc + {sext[29:0], 2'b00};
                    state  <= is_known(op, funct) ? EXEC : FETCH;
                end
                EXEC: begin
                    state <= FETCH;
                    case (op)
                        OP_RTYPE: begin
                            if (funct == FN_JR) pc <= a;
                            else begin
                                aluout <= alu_y;
                                state  <= WB;
                            end
                        end
                        OP_ADDI, OP_XORI: begin
                            aluout <= alu_y;
                            state  <= WB;
                        end
                        OP_LW, OP_SW: begin
                            aluout <= alu_y;
                            state  <= MEM;
                        end
                        OP_BEQ: if (a == b) pc <= aluout;
                        OP_BNE: if (a != b) pc <= aluout;
                        OP_J:   pc <= jump_target;
                        OP_JAL: begin
                            pc       <= jump_target;
                            regs[31] <= pc;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    if (op == OP_LW) begin
                        mdr   <= mem_rdata;
                        state <= WB;
                    end else begin
                        state <= FETCH;
                    end
                end
                WB: begin
                    if (wb_dest != 5'd0) regs[wb_dest] <= wb_val;
                    state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

`ifdef TRACE_EN
    logic [31:0] trace_pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)               trace_pc <= '0;
        else if (state == FETCH)  trace_pc <= pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == WB && wb_dest != 5'd0)
                $display("%0t pc=%h ir=%h r%0d=%h", $time, trace_pc, ir, wb_dest, wb_val);
            else if (mem_we)
                $display("%0t pc=%h ir=%h mem[%h]=%h", $time, trace_pc, ir, aluout, b);
            else if (state == EXEC && op == OP_JAL)
                $display("%0t pc=%h ir=%h r31=%h", $time, trace_pc, ir, pc);
            else if ((state == EXEC && (op == OP_J || op == OP_BEQ || op == OP_BNE ||
                      (op == OP_RTYPE && funct == FN_JR))) ||
                     (state == DECODE && !is_known(op, funct)) || state == WB)
                $display("%0t pc=%h ir=%h", $time, trace_pc, ir);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed program test for multicycle_cpu: per-instruction latency, PC and
// architectural result, plus reset recovery in the middle of an LW.
module tb_multicycle_cpu;
    import multicycle_cpu_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    multicycle_cpu #(.MEM_WORDS(1024), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset)
    );

    logic [31:0] prog [0:17] = '{
        32'h20080005, 32'h2009FFFD, 32'h01095020, 32'h01285822,
        32'h0128602A, 32'h390DFFFF, 32'hAC080100, 32'h8C100100,
        32'h20000007, 32'h15000001, 32'h200E0001, 32'h0C000010,
        32'hFC000000, 32'h20110009, 32'h0800000E, 32'h00000000,
        32'h20120042, 32'h03E00008};

    // Per retired instruction: cycles taken, pc afterwards, location to inspect (32 = mem[64]).
    int unsigned exp_cyc [0:16] = '{4,4,4,4,4,4,4,5,4,3,3,4,3,2,4,3,3};
    logic [31:0] exp_pc  [0:16] = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C,
                                    32'h20, 32'h24, 32'h2C, 32'h40, 32'h44, 32'h30, 32'h34,
                                    32'h38, 32'h38, 32'h38};
    int unsigned exp_sel [0:16] = '{8,9,10,11,12,13,32,16,0,14,31,18,31,17,17,10,8};
    logic [31:0] exp_val [0:16] = '{32'd5, 32'hFFFFFFFD, 32'd2, 32'hFFFFFFF8, 32'd1,
                                    32'h0000FFFA, 32'd5, 32'd5, 32'd0, 32'd0, 32'h30,
                                    32'h42, 32'h30, 32'd0, 32'd9, 32'd2, 32'd5};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step_instr(output int unsigned n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (dut.state != FETCH && n < 12);
    endtask

    initial begin
        int unsigned n;
        logic [31:0] obs;

        for (int i = 0; i < 1024; i++) dut.memory.mem[i] <= '0;
        #1;
        for (int i = 0; i < 18; i++) dut.memory.mem[i] <= prog[i];

        #11;
        check("rst_pc", dut.pc, 32'h0);
        check("rst_state", 32'(dut.state), 32'(FETCH));
        check("rst_ir", dut.ir, 32'h0);
        #8 reset = 1'b1;
        #1;
        check("rel_pc", dut.pc, 32'h0);
        check("rel_state", 32'(dut.state), 32'(FETCH));

        for (int k = 0; k < 17; k++) begin
            step_instr(n);
            check($sformatf("cyc%0d", k), n, exp_cyc[k]);
            check($sformatf("pc%0d", k), dut.pc, exp_pc[k]);
            obs = (exp_sel[k] == 32) ? dut.memory.mem[64] : dut.regs[exp_sel[k]];
            check($sformatf("val%0d", k), obs, exp_val[k]);
        end

        // Abort an LW one edge before its register write.
        @(negedge clk);
        reset = 1'b0;
        dut.memory.mem[0] <= 32'h8C100100;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("lw_in_wb", 32'(dut.state), 32'(WB));
        reset = 1'b0;
        #1;
        check("abort_pc", dut.pc, 32'h0);
        check("abort_state", 32'(dut.state), 32'(FETCH));
        check("abort_ir", dut.ir, 32'h0);
        check("abort_r16", dut.regs[16], 32'h0);
        check("abort_r8", dut.regs[8], 32'h0);
        check("mem_kept", dut.memory.mem[64], 32'd5);

        @(negedge clk);
        reset = 1'b1;
        step_instr(n);
        check("lw_cyc", n, 32'd5);
        check("lw_r16", dut.regs[16], 32'd5);
        check("lw_pc", dut.pc, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
